// File: rtl/prototable_update_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : prototable_update_writer_if
// Purpose  : Bundles the command channel, the protocol-table read/write port
//            and the status outputs of prototable_update_writer.
// Modports : master - the writer (takes commands, drives the table port,
//                     reports status)
//            slave  - the environment (command source, table, status sink)
// Revision : 1.0 - initial release
// ============================================================================
interface prototable_update_writer_if #(
  parameter int INDEX_BIT_LEN   = 11,
  parameter int COMMAND_BIT_LEN = 2,
  parameter int DIN_BIT_LEN     = 33
);
  // command channel
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [COMMAND_BIT_LEN-1:0] cmd_op;
  logic [INDEX_BIT_LEN-1:0]   cmd_addr;
  logic [7:0]                 cmd_proto;
  logic [INDEX_BIT_LEN-1:0]   cmd_index;
  logic [DIN_BIT_LEN-1:0]     cmd_entry;
  // protocol table port
  logic                       tbl_re;
  logic [INDEX_BIT_LEN-1:0]   tbl_raddr;
  logic [DIN_BIT_LEN-1:0]     tbl_rdata;
  logic                       tbl_we;
  logic [INDEX_BIT_LEN-1:0]   tbl_waddr;
  logic [DIN_BIT_LEN-1:0]     tbl_wdata;
  // status
  logic                       done;
  logic                       err;
  logic [15:0]                upd_count;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_proto, cmd_index, cmd_entry,
    input  tbl_rdata,
    output cmd_ready, tbl_re, tbl_raddr, tbl_we, tbl_waddr, tbl_wdata,
    output done, err, upd_count
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_proto, cmd_index, cmd_entry,
    output tbl_rdata,
    input  cmd_ready, tbl_re, tbl_raddr, tbl_we, tbl_waddr, tbl_wdata,
    input  done, err, upd_count
  );
endinterface
`default_nettype wire

// File: rtl/prototable_update_writer.sv
`default_nettype none
// ============================================================================
// Module   : prototable_update_writer
// Purpose  : Write-side controller for a protocol table. Each entry holds
//            three index fields {TCP, UDP, others}. Commands perform a
//            read-modify-write of one field (write / clear) or a whole-entry
//            write; one command is in flight at a time.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset
//            bus  - prototable_update_writer_if.master:
//                   cmd_*  command channel (valid/ready)
//                   tbl_*  table read strobe/address/data, write port
//                   done/err one-cycle completion/error pulse, upd_count
// Options  : PROTO_UPD_VERIFY_EN - when defined, every table write is read
//            back and compared; a mismatch raises err with done.
// Revision : 1.0 - initial release
// ============================================================================
module prototable_update_writer #(
  parameter int INDEX_BIT_LEN       = 11,
  parameter int COMMAND_BIT_LEN     = 2,
  parameter int DIN_BIT_LEN         = 33,
  parameter int PROTOCOL_TABLE_SIZE = 64,
  parameter int RD_LATENCY          = 1
) (
  input wire clk,
  input wire rst,
  prototable_update_writer_if.master bus
);

  localparam logic [COMMAND_BIT_LEN-1:0] OP_NOP   = COMMAND_BIT_LEN'(0);
  localparam logic [COMMAND_BIT_LEN-1:0] OP_CLEAR = COMMAND_BIT_LEN'(2);
  localparam logic [COMMAND_BIT_LEN-1:0] OP_ENTRY = COMMAND_BIT_LEN'(3);
  localparam logic [INDEX_BIT_LEN:0]     TBL_SIZE = (INDEX_BIT_LEN+1)'(PROTOCOL_TABLE_SIZE);
  localparam logic [2:0]                 LAT_LAST = 3'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WAIT  = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
`ifdef PROTO_UPD_VERIFY_EN
    ,
    S_VRD   = 3'd5,
    S_VWAIT = 3'd6
`endif
  } state_t;

  state_t state_q, state_d;

  logic [INDEX_BIT_LEN-1:0]   addr_q;
  logic [COMMAND_BIT_LEN-1:0] op_q;
  logic [7:0]                 proto_q;
  logic [INDEX_BIT_LEN-1:0]   index_q;
  logic [DIN_BIT_LEN-1:0]     wdata_q;
  logic                       err_q;
  logic [2:0]                 lat_cnt_q;
  logic [15:0]                upd_count_q;

  logic                       accept;
  logic                       addr_oor;
  logic                       lat_last;
  logic                       in_wait;
  logic                       we;
  logic [INDEX_BIT_LEN-1:0]   field_val;
  logic [DIN_BIT_LEN-1:0]     merged;

  assign addr_oor = ({1'b0, bus.cmd_addr} >= TBL_SIZE);
  assign accept   = bus.cmd_valid & bus.cmd_ready;
  assign lat_last = (lat_cnt_q == LAT_LAST);

`ifdef PROTO_UPD_VERIFY_EN
  assign in_wait  = (state_q == S_WAIT) | (state_q == S_VWAIT);
`else
  assign in_wait  = (state_q == S_WAIT);
`endif

  // Strobes are gated by rst so a reset cycle never issues a read or write.
  assign bus.cmd_ready = (state_q == S_IDLE) & ~rst;
  assign we            = (state_q == S_WR) & ~rst;
  assign bus.tbl_we    = we;
`ifdef PROTO_UPD_VERIFY_EN
  assign bus.tbl_re    = ((state_q == S_RD) | (state_q == S_VRD)) & ~rst;
`else
  assign bus.tbl_re    = (state_q == S_RD) & ~rst;
`endif
  assign bus.done      = (state_q == S_DONE) & ~rst;
  assign bus.err       = (state_q == S_DONE) & err_q & ~rst;
  assign bus.tbl_raddr = addr_q;
  assign bus.tbl_waddr = addr_q;
  assign bus.tbl_wdata = wdata_q;
  assign bus.upd_count = upd_count_q;

  // Field replacement: TCP (6) is the top field, UDP (17) the middle one,
  // every other protocol maps to the bottom field. Clear writes all ones.
  always_comb begin
    field_val = (op_q == OP_CLEAR) ? {INDEX_BIT_LEN{1'b1}} : index_q;
    merged    = bus.tbl_rdata;
    case (proto_q)
      8'd6:    merged[DIN_BIT_LEN-1 -: INDEX_BIT_LEN]     = field_val;
      8'd17:   merged[2*INDEX_BIT_LEN-1 -: INDEX_BIT_LEN] = field_val;
      default: merged[INDEX_BIT_LEN-1:0]                  = field_val;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (addr_oor || bus.cmd_op == OP_NOP) state_d = S_DONE;
          else if (bus.cmd_op == OP_ENTRY)      state_d = S_WR;
          else                                  state_d = S_RD;
        end
      end
      S_RD:    state_d = S_WAIT;
      S_WAIT:  if (lat_last) state_d = S_WR;
`ifdef PROTO_UPD_VERIFY_EN
      S_WR:    state_d = S_VRD;
      S_VRD:   state_d = S_VWAIT;
      S_VWAIT: if (lat_last) state_d = S_DONE;
`else
      S_WR:    state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      op_q        <= '0;
      proto_q     <= '0;
      index_q     <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      lat_cnt_q   <= '0;
      upd_count_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.cmd_addr;
        op_q    <= bus.cmd_op;
        proto_q <= bus.cmd_proto;
        index_q <= bus.cmd_index;
        err_q   <= addr_oor;
        if (bus.cmd_op == OP_ENTRY && !addr_oor) wdata_q <= bus.cmd_entry;
      end
      // Counts read-latency cycles; restarts on each entry into a wait state.
      if (in_wait) lat_cnt_q <= lat_cnt_q + 3'd1;
      else         lat_cnt_q <= '0;
      // Read data is valid in the last WAIT cycle only.
      if (state_q == S_WAIT && lat_last) wdata_q <= merged;
`ifdef PROTO_UPD_VERIFY_EN
      if (state_q == S_VWAIT && lat_last && bus.tbl_rdata != wdata_q) err_q <= 1'b1;
`endif
      if (we && upd_count_q != 16'hFFFF) upd_count_q <= upd_count_q + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/prototable_update_writer.md
Name: prototable_update_writer

Overview:
- Write-side controller for a subset's protocol table. Each protocol entry is DIN_BIT_LEN bits: TCP index [32:22], UDP index [21:11], others index [10:0].
- Accepts rule-update commands from the update path. Performs a read-modify-write of a single index field, a whole-entry write, or a field clear.
- Drives the table's write port (address, write enable, write data) toward the lookup-side table.
- One command in flight at a time. Completion is reported by a done pulse and a running count of writes.

Parameters:
- INDEX_BIT_LEN, 11, width of one index field and of the table address.
- COMMAND_BIT_LEN, 2, width of the command opcode.
- DIN_BIT_LEN, 33, entry width; must equal 3*INDEX_BIT_LEN.
- PROTOCOL_TABLE_SIZE, 64, number of table entries; legal addresses are 0..PROTOCOL_TABLE_SIZE-1.
- RD_LATENCY, 1, table read latency in cycles; legal values 1..4.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- cmd_valid, input, 1, command present.
- cmd_ready, output, 1, block can accept a command.
- cmd_op, input, COMMAND_BIT_LEN, opcode: 00 NOP, 01 write field, 10 clear field, 11 write entry.
- cmd_addr, input, INDEX_BIT_LEN, table entry address.
- cmd_proto, input, 8, protocol byte; selects the field.
- cmd_index, input, INDEX_BIT_LEN, new field value for op 01.
- cmd_entry, input, DIN_BIT_LEN, full entry for op 11.
- tbl_re, output, 1, table read strobe.
- tbl_raddr, output, INDEX_BIT_LEN, table read address.
- tbl_rdata, input, DIN_BIT_LEN, table read data.
- tbl_we, output, 1, table write enable.
- tbl_waddr, output, INDEX_BIT_LEN, table write address.
- tbl_wdata, output, DIN_BIT_LEN, table write data.
- done, output, 1, one-cycle completion pulse.
- err, output, 1, one-cycle error pulse, coincident with done.
- upd_count, output, 16, number of table writes issued.

Behaviour:
- Reset state, synchronous on rst:
  - FSM goes to IDLE.
  - tbl_re, tbl_we, done and err are 0.
  - tbl_raddr, tbl_waddr and tbl_wdata are 0.
  - upd_count is 0.
  - cmd_ready is 0 while rst is high.
- cmd_ready is 1 exactly when the FSM is in IDLE and rst is low.
- A command is accepted on the edge where cmd_valid && cmd_ready. All cmd_* inputs are captured on that edge.
- Field select from cmd_proto: 8'd6 selects TCP [32:22]; 8'd17 selects UDP [21:11]; any other value selects others [10:0].
- FSM states: IDLE, RD, WAIT, WR, DONE. Acceptance happens on edge T.
- Op 01 (write field):
  - RD at T+1: tbl_re=1, tbl_raddr=addr.
  - WAIT for RD_LATENCY cycles; tbl_rdata is sampled in the last WAIT cycle.
  - WR: tbl_we=1, tbl_waddr=addr, tbl_wdata = sampled entry with the selected field replaced by cmd_index and the other fields unchanged.
  - DONE: done=1.
  - Back to IDLE.
  - For RD_LATENCY=1: we at T+3, done at T+4, cmd_ready at T+5.
- Op 10 (clear field): same sequence as op 01, but the selected field is set to all ones (the invalid-index marker).
- Op 11 (write entry): IDLE→WR→DONE with no read. tbl_wdata=cmd_entry; we at T+1, done at T+2.
- Op 00 (NOP): IDLE→DONE. No read and no write; done at T+1.
- Out-of-range address (addr >= PROTOCOL_TABLE_SIZE), any op: IDLE→DONE with done=1 and err=1. No read, no write, count unchanged.
- tbl_re and tbl_we are each high for exactly one cycle per qualifying command. tbl_re and tbl_we are never high in the same cycle.
- upd_count increments by 1 in each cycle with tbl_we=1 and saturates at 16'hFFFF.
- cmd_valid while busy is ignored; the command is held by the source until accepted.
- Reset in any state aborts the command. No write is issued after rst is sampled high, even from WAIT or WR; a WR-cycle we is suppressed if rst is high in that cycle.

Optional Feature:
- Macro: PROTO_UPD_VERIFY_EN.
- Defined:
  - After WR, the FSM enters VRD (tbl_re=1, same address), then VWAIT for RD_LATENCY cycles, then compares tbl_rdata with the written tbl_wdata.
  - On mismatch, err=1 together with done in DONE.
  - Applies to ops 01, 10 and 11. For RD_LATENCY=1, op 01 done moves to T+6.
- Undefined: no readback states. err is raised only for an out-of-range address.

Test Plan:
- Reset, then op 01, addr 5, proto 6, index 11'h123; table[5]=33'h0_0000_0000, RD_LATENCY=1 → re at T+1 with raddr 5; we at T+3 with wdata {11'h123,11'h0,11'h0}; done at T+4; upd_count=1.
- Op 01, addr 5, proto 17, index 11'h0AB; table[5]={11'h123,11'h055,11'h077} → wdata {11'h123,11'h0AB,11'h077}.
- Op 10, addr 7, proto 1; table[7]={11'h001,11'h002,11'h003} → wdata {11'h001,11'h002,11'h7FF}.
- Op 11, addr 63, entry 33'h1_2345_6789 → no re; we at T+1 with that data; done at T+2. Then op 01 at addr 64 (size 64) → done and err at T+1; no we; upd_count unchanged.
- cmd_valid held during a busy op 01 → second command accepted only at T+5. rst asserted in the WAIT cycle → no we, FSM in IDLE, upd_count=0.
- With PROTO_UPD_VERIFY_EN defined: the table model corrupts bit 0 on write → err=1 with done. A clean model → err=0.
